// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 16-bit ALU: accept, decode, execute, write back.
// Legal op retires 2 cycles after accept (4 cycles/instr); instr_ready only in IDLE, so a busy controller stalls the source.
module alu_issue_ctrl #(
  parameter int NUM_REGS  = 8,
  parameter int IMM_WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  output logic        done,
  output logic        illegal,
  output logic        zero_flag,
  output logic        halted,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t      state, nxt;
  logic [15:0] instr_r;
  logic        ill_r;
  logic [15:0] regs [NUM_REGS];

  logic [2:0]  opc, rd, rs, rt;
  logic [15:0] imm_sext;
  logic        is_alu, is_halt;

  assign opc      = instr_r[15:13];
  assign rd       = instr_r[12:10];
  assign rs       = instr_r[9:7];
  assign rt       = instr_r[6:4];
  assign imm_sext = {{(16-IMM_WIDTH){instr_r[IMM_WIDTH-1]}}, instr_r[IMM_WIDTH-1:0]};
  assign is_alu   = (opc == 3'b000) || (opc == 3'b001) || (opc == 3'b010);
  assign is_halt  = (opc == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (instr_valid) nxt = DECODE;
      DECODE: begin
        if (is_halt)     nxt = HALTED;
        else if (is_alu) nxt = EXEC;
        else             nxt = WB;
      end
      EXEC:    nxt = WB;
      WB:      nxt = IDLE;
      HALTED:  nxt = HALTED;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    done        = (state == WB);
    halted      = (state == HALTED);
    illegal     = (state == WB) && ill_r;
  end

  // ill_r is only observed while done is high, so it can linger between ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      ill_r      <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) instr_r <= instr;
      if (state == DECODE) begin
        if (is_alu) begin
          alu_a      <= (rs == 3'd0) ? 16'h0000 : regs[rs];
          alu_b      <= (opc == 3'b000) ? ((rt == 3'd0) ? 16'h0000 : regs[rt]) : imm_sext;
          alu_opcode <= opc;
        end else if (!is_halt) begin
          ill_r <= 1'b1;
        end
      end
      if (state == EXEC) begin
        zero_flag <= alu_zero;
        ill_r     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == EXEC && rd != 3'd0) begin
      regs[rd] <= alu_result;
    end
  end

  assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
// Table of single instructions plus sequences for reset, back-to-back issue, busy stalls and HALT.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0000;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_opcode;
  logic        alu_zero;
  logic        done, illegal, zero_flag, halted;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;

  alu_issue_ctrl #(.NUM_REGS(8), .IMM_WIDTH(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .done        (done),
    .illegal     (illegal),
    .zero_flag   (zero_flag),
    .halted      (halted),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU: 010 subtracts, everything else adds
  assign alu_result = (alu_opcode == 3'b010) ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_zero   = (alu_result == 16'h0000);

  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) acc_cnt++;
  end

  typedef struct {
    logic [15:0] w;
    logic [2:0]  r;
    logic [15:0] val;
    logic        z;
    logic        ill;
    logic [2:0]  opc;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [6:0] lo);
    return {op, rd, rs, lo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rdreg(input logic [2:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Offer one word, drop valid after it is accepted, and measure cycles from accept to done.
  task automatic issue(input logic [15:0] w, output logic acc_ok, output int lat,
                       output logic ill_at_done, output logic done_after);
    int n;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_ok = (n < 20);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ill_at_done = illegal;
    @(negedge clk);
    done_after = done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic        acc_ok, ill_at_done, done_after;
    int          lat, a0, n;
    logic [7:0]  dmask;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_halted", halted, 0);
    chk("rst_alu", {alu_a, alu_b}, 0);
    chk("rst_zero", zero_flag, 0);
    rst_n = 1'b1;

    // Reset mid-EXEC of ADDI r1,r0,5
    @(negedge clk);
    instr = enc(3'b001, 3'd1, 3'd0, 7'd5);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("midexec_alu_b", alu_b, 16'h0005);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_halted", halted, 0);
    chk("midrst_alu_ab", {alu_a, alu_b}, 0);
    chk("midrst_opc", alu_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdreg(3'd1, v);
    chk("midrst_r1", v, 16'h0000);

    // Back-to-back ADDI r1,r0,5 / ADD r2,r1,r1 with valid held throughout
    a0 = acc_cnt;
    dmask = '0;
    @(negedge clk);
    instr = enc(3'b001, 3'd1, 3'd0, 7'd5);
    instr_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      dmask[j] = done;
      if (j == 0) instr = enc(3'b000, 3'd2, 3'd1, {3'd1, 4'd0});
      if (j == 1) chk("b2b_opc_addi", alu_opcode, 3'b001);
      if (j == 5) chk("b2b_opc_add", alu_opcode, 3'b000);
      if (j == 6) instr_valid = 1'b0;
    end
    chk("b2b_done_spacing", dmask, 8'b0100_0100);
    chk("b2b_accepts", acc_cnt - a0, 2);
    rdreg(3'd1, v);
    chk("b2b_r1", v, 16'h0005);
    rdreg(3'd2, v);
    chk("b2b_r2", v, 16'h000A);
    chk("b2b_zero", zero_flag, 0);

    // Single-instruction vectors
    tbl[0] = '{enc(3'b010, 3'd3, 3'd1, 7'h05),          3'd3, 16'h0000, 1'b1, 1'b0, 3'b010};
    tbl[1] = '{enc(3'b001, 3'd4, 3'd0, 7'h7F),          3'd4, 16'hFFFF, 1'b0, 1'b0, 3'b001};
    tbl[2] = '{enc(3'b001, 3'd5, 3'd4, 7'h01),          3'd5, 16'h0000, 1'b1, 1'b0, 3'b001};
    tbl[3] = '{enc(3'b001, 3'd0, 3'd0, 7'h03),          3'd0, 16'h0000, 1'b0, 1'b0, 3'b001};
    tbl[4] = '{enc(3'b011, 3'd1, 3'd1, 7'h05),          3'd1, 16'h0005, 1'b0, 1'b1, 3'b001};
    tbl[5] = '{enc(3'b000, 3'd6, 3'd2, {3'd4, 4'd0}),   3'd6, 16'h0009, 1'b0, 1'b0, 3'b000};
    tbl[6] = '{enc(3'b010, 3'd7, 3'd2, 7'h7A),          3'd7, 16'h0010, 1'b0, 1'b0, 3'b010};
    tbl[7] = '{enc(3'b010, 3'd7, 3'd7, 7'h10),          3'd7, 16'h0000, 1'b1, 1'b0, 3'b010};
    tbl[8] = '{enc(3'b110, 3'd7, 3'd0, 7'h00),          3'd7, 16'h0000, 1'b1, 1'b1, 3'b010};
    tbl[9] = '{enc(3'b000, 3'd1, 3'd1, {3'd0, 4'd0}),   3'd1, 16'h0005, 1'b0, 1'b0, 3'b000};

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].w, acc_ok, lat, ill_at_done, done_after);
      chk($sformatf("v%0d_accept", i), acc_ok, 1);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].ill ? 1 : 2);
      chk($sformatf("v%0d_illegal", i), ill_at_done, tbl[i].ill);
      chk($sformatf("v%0d_done_1cyc", i), done_after, 0);
      rdreg(tbl[i].r, v);
      chk($sformatf("v%0d_reg", i), v, tbl[i].val);
      chk($sformatf("v%0d_zero", i), zero_flag, tbl[i].z);
      chk($sformatf("v%0d_opc", i), alu_opcode, tbl[i].opc);
    end

    // Illegal 101 with valid held while busy
    a0 = acc_cnt;
    @(negedge clk);
    instr = enc(3'b101, 3'd2, 3'd1, 7'h00);
    instr_valid = 1'b1;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("illheld_done", done, 1);
    chk("illheld_illegal", illegal, 1);
    chk("illheld_latency", n, 2);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("illheld_done_1cyc", done, 0);
    repeat (2) @(negedge clk);
    chk("illheld_accepts", acc_cnt - a0, 1);
    rdreg(3'd2, v);
    chk("illheld_r2", v, 16'h000A);
    chk("illheld_zero", zero_flag, 0);

    // HALT, then a following ADDI must never be accepted
    @(negedge clk);
    instr = 16'hE000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_ready", instr_ready, 0);
    chk("halt_done", done, 0);
    a0 = acc_cnt;
    instr = enc(3'b001, 3'd1, 3'd0, 7'd9);
    instr_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("halt_no_accept", acc_cnt - a0, 0);
    chk("halt_still", halted, 1);
    chk("halt_ready_still", instr_ready, 0);
    rdreg(3'd1, v);
    chk("halt_r1", v, 16'h0005);
    chk("halt_zero", zero_flag, 0);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1);
    rdreg(3'd1, v);
    chk("post_rst_r1", v, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
